// File: rtl/io_read_arbiter.sv
// CPU I/O read arbiter: fixed-priority responder selection, byte latch for the read cycle,
// wait-state insertion with ready/timeout for slow responders, and decode-conflict counting.
module io_read_arbiter #(
    parameter int N_SRC    = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic               clk28,
    input  logic               rst,
    input  logic               ioreq,
    input  logic               rd,
    input  logic               clkcpu_ck,
    input  logic [N_SRC-1:0]   src_active,
    input  logic [8*N_SRC-1:0] src_data,
    input  logic [N_SRC-1:0]   src_slow,
    input  logic [N_SRC-1:0]   src_ready,
    output logic [N_SRC-1:0]   grant,
    output logic [7:0]         d_out,
    output logic               d_out_active,
    output logic               cpu_wait,
    output logic               conflict,
    output logic               timeout,
    output logic [7:0]         conflict_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

    state_t           state_reg;
    logic [7:0]       wait_cnt_reg;

    logic             rdcyc;
    logic [N_SRC-1:0] higher_active;
    logic [N_SRC-1:0] sel_onehot;
    logic [7:0]       sel_terms [N_SRC];
    logic [7:0]       gnt_terms [N_SRC];
    logic [7:0]       sel_data;
    logic [7:0]       gnt_data;
    logic             sel_slow;
    logic             sel_ready;
    logic             gnt_ready;
    logic             multi_active;

    assign rdcyc = ioreq & rd;

    // higher_active[i] is set when any source with a lower index (higher priority) is active
    genvar gi;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_src
            if (gi == 0) begin : g_first
                assign higher_active[gi] = 1'b0;
            end else begin : g_rest
                assign higher_active[gi] = higher_active[gi-1] | src_active[gi-1];
            end
            assign sel_onehot[gi] = src_active[gi] & ~higher_active[gi];
            assign sel_terms[gi]  = src_data[8*gi +: 8] & {8{sel_onehot[gi]}};
            assign gnt_terms[gi]  = src_data[8*gi +: 8] & {8{grant[gi]}};
        end
    endgenerate

    always_comb begin
        sel_data = '0;
        gnt_data = '0;
        for (int i = 0; i < N_SRC; i++) begin
            sel_data = sel_data | sel_terms[i];
            gnt_data = gnt_data | gnt_terms[i];
        end
    end

    assign sel_slow     = |(sel_onehot & src_slow);
    assign sel_ready    = |(sel_onehot & src_ready);
    assign gnt_ready    = |(grant & src_ready);
    assign multi_active = |(src_active & higher_active);

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            grant          <= '0;
            d_out          <= 8'hFF;
            d_out_active   <= 1'b0;
            cpu_wait       <= 1'b0;
            conflict       <= 1'b0;
            timeout        <= 1'b0;
            conflict_count <= 8'd0;
            wait_cnt_reg   <= 8'd0;
        end else begin
            conflict <= 1'b0;
            timeout  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (rdcyc) begin
                        state_reg <= ST_SAMPLE;
                    end
                end

                ST_SAMPLE: begin
                    if (!rdcyc) begin
                        state_reg    <= ST_IDLE;
                        grant        <= '0;
                        d_out_active <= 1'b0;
                        cpu_wait     <= 1'b0;
                    end else begin
                        grant <= sel_onehot;
                        if (multi_active) begin
                            conflict <= 1'b1;
                            if (conflict_count != 8'hFF) begin
                                conflict_count <= conflict_count + 8'd1;
                            end
                        end
                        // With no responder the bus is left undriven so the pull-ups supply #FF
                        if (sel_onehot == '0) begin
                            state_reg <= ST_HOLD;
                        end else if (!sel_slow || sel_ready) begin
                            d_out        <= sel_data;
                            d_out_active <= 1'b1;
                            state_reg    <= ST_HOLD;
                        end else begin
                            wait_cnt_reg <= 8'd0;
                            cpu_wait     <= 1'b1;
                            state_reg    <= ST_WAIT;
                        end
                    end
                end

                ST_WAIT: begin
                    if (!rdcyc) begin
                        state_reg    <= ST_IDLE;
                        grant        <= '0;
                        d_out_active <= 1'b0;
                        cpu_wait     <= 1'b0;
                    end else if (gnt_ready) begin
                        // ready is checked first so it wins a tie with the limit
                        d_out        <= gnt_data;
                        d_out_active <= 1'b1;
                        cpu_wait     <= 1'b0;
                        state_reg    <= ST_HOLD;
                    end else if (wait_cnt_reg == WAIT_LIMIT) begin
                        d_out        <= 8'hFF;
                        d_out_active <= 1'b1;
                        cpu_wait     <= 1'b0;
                        timeout      <= 1'b1;
                        state_reg    <= ST_HOLD;
                    end else if (clkcpu_ck) begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end

                ST_HOLD: begin
                    if (!rdcyc) begin
                        state_reg    <= ST_IDLE;
                        grant        <= '0;
                        d_out_active <= 1'b0;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_read_arbiter.sv
// Randomized scoreboard bench for io_read_arbiter: the driver predicts each read from the
// priority/wait/timeout rules and queues it; a negedge monitor checks every presented byte.
module tb_io_read_arbiter;

    localparam int N_SRC    = 4;
    localparam int WAIT_MAX = 15;

    logic               clk28;
    logic               rst;
    logic               ioreq;
    logic               rd;
    logic               clkcpu_ck;
    logic [N_SRC-1:0]   src_active;
    logic [8*N_SRC-1:0] src_data;
    logic [N_SRC-1:0]   src_slow;
    logic [N_SRC-1:0]   src_ready;
    logic [N_SRC-1:0]   grant;
    logic [7:0]         d_out;
    logic               d_out_active;
    logic               cpu_wait;
    logic               conflict;
    logic               timeout;
    logic [7:0]         conflict_count;

    io_read_arbiter #(.N_SRC(N_SRC), .WAIT_MAX(WAIT_MAX)) dut (
        .clk28          (clk28),
        .rst            (rst),
        .ioreq          (ioreq),
        .rd             (rd),
        .clkcpu_ck      (clkcpu_ck),
        .src_active     (src_active),
        .src_data       (src_data),
        .src_slow       (src_slow),
        .src_ready      (src_ready),
        .grant          (grant),
        .d_out          (d_out),
        .d_out_active   (d_out_active),
        .cpu_wait       (cpu_wait),
        .conflict       (conflict),
        .timeout        (timeout),
        .conflict_count (conflict_count)
    );

    typedef struct {
        logic [3:0] grant;
        logic [7:0] d;
        logic       to;
        int         conf;
        logic [7:0] cnt;
        logic       waited;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;

    int nvec = 0;
    int nfail = 0;
    int model_cnt = 0;
    int model_pending = 0;
    int model_timeouts = 0;
    int seen_timeouts = 0;
    int conf_seen = 0;
    bit waited_seen = 0;
    bit prev_act = 0;
    bit prev_wait = 0;
    logic [2:0] ck_div;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        clk28 = 1'b0;
        forever #5 clk28 = ~clk28;
    end

    // CPU clock strobe: one clk28 cycle in eight
    initial begin
        ck_div    = 3'd0;
        clkcpu_ck = 1'b0;
        forever begin
            @(posedge clk28);
            #1;
            ck_div    = ck_div + 3'd1;
            clkcpu_ck = (ck_div == 3'd7);
        end
    end

    // Monitor: pops an expectation whenever d_out_active rises
    initial begin
        forever begin
            @(negedge clk28);
            if (rst) begin
                conf_seen   = 0;
                waited_seen = 0;
                prev_act    = 0;
                prev_wait   = 0;
            end else begin
                if (conflict) conf_seen++;
                if (timeout) begin
                    seen_timeouts++;
                    check("timeout_with_data", d_out_active, 1);
                end
                if (cpu_wait) waited_seen = 1;
                if (d_out_active && !prev_act) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_data", 1, 0);
                    end else begin
                        cur = exp_q.pop_front();
                        check("grant", grant, cur.grant);
                        check("d_out", d_out, cur.d);
                        check("timeout", timeout, cur.to);
                        check("conflict_pulses", conf_seen, cur.conf);
                        check("conflict_count", conflict_count, cur.cnt);
                        check("waited", waited_seen, cur.waited);
                        check("wait_released", cpu_wait, 0);
                        $display("read grant=%b d_out=%02h timeout=%b conflicts=%0d count=%0d",
                                 grant, d_out, timeout, conf_seen, conflict_count);
                    end
                    conf_seen   = 0;
                    waited_seen = 0;
                end else if (d_out_active) begin
                    check("hold_grant", grant, cur.grant);
                    check("hold_d_out", d_out, cur.d);
                end else if (prev_wait && !cpu_wait) begin
                    waited_seen = 0;
                end
                prev_act  = d_out_active;
                prev_wait = cpu_wait;
            end
        end
    end

    // One complete read cycle; starts and ends 1 time unit after a rising edge
    task automatic do_read(input logic [3:0] act, input logic [31:0] dat, input logic [3:0] slow,
                           input logic [3:0] rdy0, input int k, input int hold, input bit abort);
        int w;
        bit wait_path;
        bit do_abort;
        int n;
        logic [31:0] r;
        exp_t e;

        w = -1;
        for (int i = 0; i < N_SRC; i++) begin
            if (act[i] && w < 0) w = i;
        end
        if ($countones(act) > 1) begin
            model_pending++;
            if (model_cnt < 255) model_cnt++;
        end
        wait_path = (w >= 0) && slow[w] && !rdy0[w];
        do_abort  = abort && wait_path;
        if (w >= 0 && !do_abort) begin
            e.grant  = 4'b0001 << w;
            e.to     = wait_path && (k > WAIT_MAX);
            e.d      = e.to ? 8'hFF : dat[8*w +: 8];
            e.conf   = model_pending;
            e.cnt    = 8'(model_cnt);
            e.waited = wait_path;
            if (e.to) model_timeouts++;
            model_pending = 0;
            exp_q.push_back(e);
        end

        src_active = act;
        src_data   = dat;
        src_slow   = slow;
        src_ready  = rdy0;
        ioreq      = 1'b1;
        rd         = 1'b1;
        @(posedge clk28);
        @(posedge clk28);
        #1;
        if (w < 0) begin
            check("none_grant", grant, 0);
            check("none_active", d_out_active, 0);
            $display("read no responder act=%b", act);
        end else if (wait_path) begin
            check("wait_raised", cpu_wait, 1);
            check("wait_no_data", d_out_active, 0);
            if (do_abort) begin
                @(posedge clk28);
                #1;
                rd    = 1'b0;
                ioreq = 1'b0;
                @(posedge clk28);
                #1;
                check("abort_wait", cpu_wait, 0);
                check("abort_grant", grant, 0);
                check("abort_active", d_out_active, 0);
                $display("read aborted during wait act=%b", act);
                return;
            end
            n = 0;
            while (n < k) begin
                @(posedge clk28);
                if (clkcpu_ck) n++;
            end
            #1;
            src_ready[w] = 1'b1;
            @(posedge clk28);
            #1;
            check("wait_done", cpu_wait, 0);
            check("wait_active", d_out_active, 1);
        end else begin
            check("fast_latency", d_out_active, 1);
            check("fast_no_wait", cpu_wait, 0);
        end

        // Sources change freely while the latched byte is held
        for (int h = 0; h < hold; h++) begin
            r          = $urandom;
            src_data   = $urandom;
            src_active = r[3:0];
            src_ready  = r[7:4];
            @(posedge clk28);
            #1;
            if (w < 0) check("none_hold_active", d_out_active, 0);
        end
        rd    = 1'b0;
        ioreq = 1'b0;
        @(posedge clk28);
        #1;
        check("end_active", d_out_active, 0);
        check("end_grant", grant, 0);
        check("end_wait", cpu_wait, 0);
    endtask

    initial begin
        logic [31:0] r;
        exp_t e;

        rst        = 1'b1;
        ioreq      = 1'b0;
        rd         = 1'b0;
        src_active = '0;
        src_data   = '0;
        src_slow   = '0;
        src_ready  = '0;
        #2;
        check("rst_grant", grant, 0);
        check("rst_d_out", d_out, 8'hFF);
        check("rst_active", d_out_active, 0);
        check("rst_wait", cpu_wait, 0);
        check("rst_conflict", conflict, 0);
        check("rst_timeout", timeout, 0);
        check("rst_count", conflict_count, 0);
        repeat (2) @(posedge clk28);
        #1;
        rst = 1'b0;

        // Write cycle: nothing responds
        ioreq      = 1'b1;
        rd         = 1'b0;
        src_active = 4'b1111;
        src_data   = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk28);
            #1;
            check("write_grant", grant, 0);
            check("write_active", d_out_active, 0);
            check("write_d_out", d_out, 8'hFF);
            check("write_wait", cpu_wait, 0);
            check("write_count", conflict_count, 0);
        end
        ioreq = 1'b0;
        $display("write cycle ignored");
        @(posedge clk28);
        #1;

        do_read(4'b0010, 32'h0000A500, 4'b0000, 4'b0000, 1, 3, 0);
        do_read(4'b0101, 32'h00330011, 4'b0000, 4'b0000, 1, 2, 0);
        do_read(4'b0100, 32'h003C0000, 4'b0100, 4'b0000, 5, 2, 0);
        do_read(4'b0100, 32'h005A0000, 4'b0100, 4'b0000, 16, 2, 0);
        do_read(4'b0100, 32'h00690000, 4'b0100, 4'b0000, 15, 2, 0);
        do_read(4'b0100, 32'h00770000, 4'b0100, 4'b0000, 14, 1, 0);
        do_read(4'b0000, 32'h12345678, 4'b0000, 4'b0000, 1, 2, 0);
        do_read(4'b1100, 32'h44550000, 4'b0100, 4'b0000, 20, 1, 1);
        do_read(4'b1000, 32'h99000000, 4'b0000, 4'b0000, 1, 1, 0);

        for (int i = 0; i < 300; i++) begin
            do_read(4'b0101, 32'h00330011, 4'b0000, 4'b0000, 1, 1, 0);
        end
        check("count_saturated", conflict_count, 255);

        // Asynchronous reset while holding a byte
        e.grant = 4'b0001; e.d = 8'hC3; e.to = 1'b0; e.conf = model_pending;
        e.cnt = 8'(model_cnt); e.waited = 1'b0;
        model_pending = 0;
        exp_q.push_back(e);
        src_active = 4'b0001;
        src_data   = 32'h000000C3;
        src_slow   = 4'b0000;
        src_ready  = 4'b0000;
        ioreq      = 1'b1;
        rd         = 1'b1;
        @(posedge clk28);
        @(posedge clk28);
        @(negedge clk28);
        #1;
        rst = 1'b1;
        #1;
        check("arst_grant", grant, 0);
        check("arst_d_out", d_out, 8'hFF);
        check("arst_active", d_out_active, 0);
        check("arst_wait", cpu_wait, 0);
        check("arst_count", conflict_count, 0);
        check("arst_queue", exp_q.size(), 0);
        $display("reset asserted during hold");
        exp_q.delete();
        model_cnt     = 0;
        model_pending = 0;
        rd    = 1'b0;
        ioreq = 1'b0;
        repeat (2) @(posedge clk28);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 150; i++) begin
            r = $urandom;
            do_read(r[3:0], $urandom, r[7:4], ((r[9:8] == 2'd0) ? r[13:10] : 4'b0000),
                    int'($urandom_range(1, 18)), int'($urandom_range(1, 3)),
                    ($urandom_range(0, 9) == 0));
        end

        repeat (3) @(posedge clk28);
        #1;
        check("final_queue_empty", exp_q.size(), 0);
        check("final_count", conflict_count, model_cnt);
        check("final_timeouts", seen_timeouts, model_timeouts);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #5_000_000;
        nfail++;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
